cpu_mc: RTL and testbench
=========================

# cpu_mc

Parametrised multi-cycle successor to the single-cycle 8-bit processor core. It executes the existing instruction set plus bne, shifts/rotate, memory load/store and halt. Instruction and data memories are reached through busywait handshakes, so slow memories stall the core cleanly. It sits between the instruction memory / cache and the data memory / cache at the top of the processor.

## Interface
Parameters:
- DATA_W, 8, datapath, register and data-address width (≥ 8).
- REG_CNT, 8, number of general registers (power of two, 2–256); register fields use their low log2(REG_CNT) bits.
- PC_W, 32, program-counter width.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- PC  out  PC_W  instruction address.
- INSTRUCTION  in  32  instruction word for PC.
- INSTR_BUSYWAIT  in  1  high = INSTRUCTION not yet valid.
- MEM_READ  out  1  data-memory read request.
- MEM_WRITE  out  1  data-memory write request.
- MEM_ADDRESS  out  DATA_W  data address.
- MEM_WRITEDATA  out  DATA_W  store data.
- MEM_READDATA  in  DATA_W  load data.
- MEM_BUSYWAIT  in  1  high = data access in progress.
- HALTED  out  1  core stopped by halt.

## Operation
- Instruction fields: opcode[31:24], rd/offset[23:16], rt[15:8], rs/imm[7:0].
- Opcodes:
  - Existing set: 0x00 loadi rd=imm; 0x01 mov rd=rs; 0x02 add rd=rt+rs; 0x03 sub rd=rt−rs; 0x04 and; 0x05 or; 0x06 j; 0x07 beq (rt==rs).
  - New: 0x08 bne; 0x09 sll; 0x0A srl; 0x0B sra; 0x0C ror; 0x0D lwd rd=M[rs]; 0x0E lwi rd=M[imm]; 0x0F swd M[rs]=rt; 0x10 swi M[imm]=rt; 0xFF halt.
  - Any other opcode is a nop: PC+4, no write.
- Arithmetic is modulo 2^DATA_W. imm is zero-extended to DATA_W when DATA_W > 8.
- Shifts: operand is rt, amount is imm unsigned.
  - sll/srl with amount ≥ DATA_W → 0.
  - sra with amount ≥ DATA_W → all bits equal rt's MSB.
  - ror uses amount mod DATA_W.
- Branch/jump target = PC+4 + (sign-extended offset << 2). Not-taken → PC+4.
- FSM states:
  - FETCH: present PC. On an edge with INSTR_BUSYWAIT=0, latch INSTRUCTION into IR → EXEC. Otherwise stay.
  - EXEC:
    - ALU ops write rd.
    - Branch, jump and nop update PC.
    - All of these go → FETCH.
    - Memory ops latch MEM_ADDRESS/MEM_WRITEDATA, set MEM_READ or MEM_WRITE → MEM.
    - halt sets HALTED → HALT.
  - MEM: hold request and address. On an edge with MEM_BUSYWAIT=0: load writes MEM_READDATA to rd; clear request; PC ← PC+4 → FETCH.
  - HALT: absorbing. PC frozen, no requests, exits only on RESET.
- Register file: registers are never read-modify-written across states; writes occur only on the EXEC or MEM completion edge.

## Timing
- Reset (asynchronous, immediate):
  - PC=0, state FETCH, IR=0.
  - All registers 0.
  - MEM_READ=MEM_WRITE=0, MEM_ADDRESS=MEM_WRITEDATA=0, HALTED=0.
- Reset mid-MEM drops the request the same instant; the memory must tolerate an abandoned access.
- Latency with zero-wait memories:
  - ALU, branch, jump: 2 cycles.
  - load/store: 3 cycles.
  - Each cycle of INSTR_BUSYWAIT or MEM_BUSYWAIT adds exactly one cycle.
- Handshake:
  - MEM_READ/MEM_WRITE are registered. They assert on the edge leaving EXEC and deassert on the completion edge.
  - The memory must raise MEM_BUSYWAIT combinationally in the first request cycle if it needs more than that cycle.
  - MEM_READ and MEM_WRITE are never high together.
- INSTRUCTION is sampled only in FETCH. Changes in other states are ignored.
- PC changes only on the EXEC edge (non-memory op) or the MEM completion edge.
- No #delays in RTL; everything updates on the clock edge.

## Structure
- Shared package cpu_mc_pkg: opcode localparams, FSM state enum, field bit positions.
- One natural sub-module: barrel_shifter (parametrised DATA_W; sll/srl/sra/ror with saturation rules), combinational.
- Register file, decoder and FSM live in cpu_mc.

## Test plan
- Reset, then loadi r1,5; loadi r2,3; sub r3,r1,r2 with zero-wait memories → r3=2, PC=12 after 6 cycles; assert RESET mid-run → PC=0, regs 0 within the same cycle.
- r1=0x81: sll 1 → 0x02; srl 9 → 0x00; sra 9 → 0xFF; ror 1 → 0xC0 (DATA_W=8).
- beq with equal regs at PC=8, offset=−3 → PC=0; bne with equal regs → PC=12; j offset=+2 at PC=0 → PC=12.
- swi M[0x10]=0xAA then lwi r4,0x10 with MEM_BUSYWAIT held 3 cycles → MEM_WRITE high 4 cycles with address 0x10 and data 0xAA; r4=0xAA; PC advances only on completion edge.
- INSTR_BUSYWAIT held 2 cycles in FETCH → PC stable, no register write; then halt (0xFF) → HALTED=1, PC frozen for 20 cycles until RESET.
- DATA_W=16, REG_CNT=16: add r15=0xFFFF+2 → 0x0001; unknown opcode 0x42 → nop, PC+4.

Source files
------------

// File: rtl/cpu_mc_pkg.sv
// Shared definitions for the multi-cycle core: opcodes, instruction field positions,
// FSM state encoding and shifter operation select.
package cpu_mc_pkg;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;
    localparam logic [7:0] OP_BNE   = 8'h08;
    localparam logic [7:0] OP_SLL   = 8'h09;
    localparam logic [7:0] OP_SRL   = 8'h0A;
    localparam logic [7:0] OP_SRA   = 8'h0B;
    localparam logic [7:0] OP_ROR   = 8'h0C;
    localparam logic [7:0] OP_LWD   = 8'h0D;
    localparam logic [7:0] OP_LWI   = 8'h0E;
    localparam logic [7:0] OP_SWD   = 8'h0F;
    localparam logic [7:0] OP_SWI   = 8'h10;
    localparam logic [7:0] OP_HALT  = 8'hFF;

    localparam int OPC_LSB = 24;
    localparam int RD_LSB  = 16;
    localparam int RT_LSB  = 8;
    localparam int RS_LSB  = 0;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXEC,
        ST_MEM,
        ST_HALT
    } state_e;

    typedef enum logic [1:0] {
        SH_SLL,
        SH_SRL,
        SH_SRA,
        SH_ROR
    } shift_op_e;

endpackage

// File: rtl/cpu_mc_barrel_shifter.sv
// Combinational shifter/rotator; oversize amounts saturate for shifts and wrap for rotate.
module barrel_shifter
    import cpu_mc_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] operand_i,
    input  logic [7:0]        amount_i,
    input  shift_op_e         op_i,
    output logic [DATA_W-1:0] result_o
);

    logic        saturate;
    logic [31:0] rot_amt;

    assign saturate = 32'(amount_i) >= 32'(DATA_W);
    assign rot_amt  = 32'(amount_i) % 32'(DATA_W);

    always_comb begin
        result_o = operand_i;
        case (op_i)
            SH_SLL: result_o = saturate ? '0 : operand_i << amount_i;
            SH_SRL: result_o = saturate ? '0 : operand_i >> amount_i;
            SH_SRA: result_o = saturate ? {DATA_W{operand_i[DATA_W-1]}}
                                        : DATA_W'($signed(operand_i) >>> amount_i);
            // A zero rotate shifts the left half out entirely, leaving the operand.
            SH_ROR: result_o = (operand_i >> rot_amt) | (operand_i << (32'(DATA_W) - rot_amt));
            default: result_o = operand_i;
        endcase
    end

endmodule

// File: rtl/cpu_mc.sv
// Multi-cycle core: FETCH -> EXEC -> (MEM) -> FETCH, with busywait handshakes on both
// memories and an absorbing HALT state left only through RESET.
module cpu_mc
    import cpu_mc_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int REG_CNT = 8,
    parameter int PC_W    = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    output logic [PC_W-1:0]   PC,
    input  logic [31:0]       INSTRUCTION,
    input  logic              INSTR_BUSYWAIT,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [DATA_W-1:0] MEM_ADDRESS,
    output logic [DATA_W-1:0] MEM_WRITEDATA,
    input  logic [DATA_W-1:0] MEM_READDATA,
    input  logic              MEM_BUSYWAIT,
    output logic              HALTED
);

    localparam int RA_W = $clog2(REG_CNT);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic              mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d, halted_q, halted_d;
    logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [DATA_W-1:0] regs_q [REG_CNT];

    logic              rf_we;
    logic [RA_W-1:0]   rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    logic [7:0]        opcode;
    logic [RA_W-1:0]   rd_idx, rt_idx, rs_idx;
    logic [DATA_W-1:0] imm_ext, rt_val, rs_val, shift_res;
    logic [PC_W-1:0]   pc_plus4, br_target;
    shift_op_e         shift_op;
    logic              unused_ir;

    assign opcode    = ir_q[OPC_LSB +: 8];
    assign rd_idx    = ir_q[RD_LSB +: RA_W];
    assign rt_idx    = ir_q[RT_LSB +: RA_W];
    assign rs_idx    = ir_q[RS_LSB +: RA_W];
    assign rt_val    = regs_q[rt_idx];
    assign rs_val    = regs_q[rs_idx];
    assign pc_plus4  = pc_q + PC_W'(4);
    assign br_target = pc_plus4 + {{(PC_W-10){ir_q[RD_LSB+7]}}, ir_q[RD_LSB +: 8], 2'b00};
    assign unused_ir = &{1'b0, ir_q[RT_LSB +: 8]};

    always_comb begin
        imm_ext      = '0;
        imm_ext[7:0] = ir_q[RS_LSB +: 8];
    end

    always_comb begin
        case (opcode)
            OP_SRL:  shift_op = SH_SRL;
            OP_SRA:  shift_op = SH_SRA;
            OP_ROR:  shift_op = SH_ROR;
            default: shift_op = SH_SLL;
        endcase
    end

    barrel_shifter #(.DATA_W(DATA_W)) u_shifter (
        .operand_i (rt_val),
        .amount_i  (ir_q[RS_LSB +: 8]),
        .op_i      (shift_op),
        .result_o  (shift_res)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        mem_rd_d = mem_rd_q;
        mem_wr_d = mem_wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        halted_d = halted_q;
        rf_we    = 1'b0;
        rf_waddr = rd_idx;
        rf_wdata = '0;
        case (state_q)
            ST_FETCH: begin
                if (!INSTR_BUSYWAIT) begin
                    ir_d    = INSTRUCTION;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                pc_d    = pc_plus4;
                case (opcode)
                    OP_LOADI: begin rf_we = 1'b1; rf_wdata = imm_ext;         end
                    OP_MOV:   begin rf_we = 1'b1; rf_wdata = rs_val;          end
                    OP_ADD:   begin rf_we = 1'b1; rf_wdata = rt_val + rs_val; end
                    OP_SUB:   begin rf_we = 1'b1; rf_wdata = rt_val - rs_val; end
                    OP_AND:   begin rf_we = 1'b1; rf_wdata = rt_val & rs_val; end
                    OP_OR:    begin rf_we = 1'b1; rf_wdata = rt_val | rs_val; end
                    OP_SLL, OP_SRL, OP_SRA, OP_ROR: begin
                        rf_we    = 1'b1;
                        rf_wdata = shift_res;
                    end
                    OP_J:   pc_d = br_target;
                    OP_BEQ: if (rt_val == rs_val) pc_d = br_target;
                    OP_BNE: if (rt_val != rs_val) pc_d = br_target;
                    OP_LWD, OP_LWI, OP_SWD, OP_SWI: begin
                        // PC holds until the access completes.
                        pc_d     = pc_q;
                        state_d  = ST_MEM;
                        addr_d   = (opcode == OP_LWD || opcode == OP_SWD) ? rs_val : imm_ext;
                        wdata_d  = rt_val;
                        mem_rd_d = (opcode == OP_LWD || opcode == OP_LWI);
                        mem_wr_d = (opcode == OP_SWD || opcode == OP_SWI);
                    end
                    OP_HALT: begin
                        pc_d     = pc_q;
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                if (!MEM_BUSYWAIT) begin
                    rf_we    = mem_rd_q;
                    rf_wdata = MEM_READDATA;
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    pc_d     = pc_plus4;
                    state_d  = ST_FETCH;
                end
            end
            ST_HALT: ;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            mem_rd_q <= mem_rd_d;
            mem_wr_q <= mem_wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            halted_q <= halted_d;
        end
    end

    for (genvar gi = 0; gi < REG_CNT; gi++) begin : g_regs
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                regs_q[gi] <= '0;
            end else if (rf_we && rf_waddr == RA_W'(gi)) begin
                regs_q[gi] <= rf_wdata;
            end
        end
    end

    assign PC            = pc_q;
    assign MEM_READ      = mem_rd_q;
    assign MEM_WRITE     = mem_wr_q;
    assign MEM_ADDRESS   = addr_q;
    assign MEM_WRITEDATA = wdata_q;
    assign HALTED        = halted_q;

endmodule

// File: tb/tb_cpu_mc.sv
// Runs an 8-bit/8-register core and a 16-bit/16-register core in lockstep on the same
// instruction stream and checks both against an instruction-level reference model.
module tb_cpu_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ibusy, mbusy;
    logic [31:0] instr;
    logic [31:0] pc8, pc16;
    logic        rd8_o, wr8_o, rd16_o, wr16_o, halt8, halt16;
    logic [7:0]  addr8, wd8, rdata8;
    logic [15:0] addr16, wd16, rdata16;

    cpu_mc u_dut8 (
        .CLK(clk), .RESET(rst), .PC(pc8), .INSTRUCTION(instr), .INSTR_BUSYWAIT(ibusy),
        .MEM_READ(rd8_o), .MEM_WRITE(wr8_o), .MEM_ADDRESS(addr8), .MEM_WRITEDATA(wd8),
        .MEM_READDATA(rdata8), .MEM_BUSYWAIT(mbusy), .HALTED(halt8)
    );

    cpu_mc #(.DATA_W(16), .REG_CNT(16), .PC_W(32)) u_dut16 (
        .CLK(clk), .RESET(rst), .PC(pc16), .INSTRUCTION(instr), .INSTR_BUSYWAIT(ibusy),
        .MEM_READ(rd16_o), .MEM_WRITE(wr16_o), .MEM_ADDRESS(addr16), .MEM_WRITEDATA(wd16),
        .MEM_READDATA(rdata16), .MEM_BUSYWAIT(mbusy), .HALTED(halt16)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state, index 0 = 8-bit core, 1 = 16-bit core.
    logic [15:0] mregs [2][16];
    logic [31:0] mpc [2];
    bit          mhalt [2];
    logic [15:0] dm0 [int];
    logic [15:0] dm1 [int];

    logic [7:0] alu_ops [10] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h09, 8'h0A, 8'h0B, 8'h0C};

    function automatic int dwk(int k); return (k == 0) ? 8 : 16; endfunction
    function automatic int rck(int k); return (k == 0) ? 8 : 16; endfunction

    function automatic logic [31:0] o_pc(int k);   return (k == 0) ? pc8 : pc16; endfunction
    function automatic logic [1:0]  o_req(int k);  return (k == 0) ? {rd8_o, wr8_o} : {rd16_o, wr16_o}; endfunction
    function automatic logic [15:0] o_addr(int k); return (k == 0) ? {8'h00, addr8} : addr16; endfunction
    function automatic logic [15:0] o_wd(int k);   return (k == 0) ? {8'h00, wd8} : wd16; endfunction
    function automatic logic        o_halt(int k); return (k == 0) ? halt8 : halt16; endfunction

    function automatic bit dm_has(int k, logic [15:0] a);
        return (k == 0) ? bit'(dm0.exists(int'(a))) : bit'(dm1.exists(int'(a)));
    endfunction
    function automatic logic [15:0] dm_get(int k, logic [15:0] a);
        return (k == 0) ? dm0[int'(a)] : dm1[int'(a)];
    endfunction

    task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s/w%0d observed=%h expected=%h", tag, dwk(k), obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 16; r++) mregs[k][r] = '0;
            mpc[k]   = '0;
            mhalt[k] = 1'b0;
        end
    endtask

    function automatic logic [15:0] model_addr(int k, logic [31:0] ins);
        if (ins[31:24] == 8'h0D || ins[31:24] == 8'h0F) return mregs[k][int'(ins[7:0]) % rck(k)];
        return {8'h00, ins[7:0]};
    endfunction

    function automatic logic [15:0] model_wdata(int k, logic [31:0] ins);
        return mregs[k][int'(ins[15:8]) % rck(k)];
    endfunction

    task automatic model_exec(input int k, input logic [31:0] ins, input logic [15:0] rdv);
        int dw, rc, rd, rt, rs, amt, sh;
        longint m, a, b, imm, r, sv, off, npc;
        bit w;
        dw  = dwk(k);
        rc  = rck(k);
        m   = (longint'(1) << dw) - 1;
        rd  = int'(ins[23:16]) % rc;
        rt  = int'(ins[15:8]) % rc;
        rs  = int'(ins[7:0]) % rc;
        a   = longint'(mregs[k][rt]);
        b   = longint'(mregs[k][rs]);
        imm = longint'(ins[7:0]);
        amt = int'(ins[7:0]);
        off = longint'($signed(ins[23:16]));
        npc = longint'(mpc[k]) + 4;
        w   = 1'b0;
        r   = 0;
        case (ins[31:24])
            8'h00: begin w = 1'b1; r = imm;   end
            8'h01: begin w = 1'b1; r = b;     end
            8'h02: begin w = 1'b1; r = a + b; end
            8'h03: begin w = 1'b1; r = a - b; end
            8'h04: begin w = 1'b1; r = a & b; end
            8'h05: begin w = 1'b1; r = a | b; end
            8'h06: npc = npc + off * 4;
            8'h07: if (a == b) npc = npc + off * 4;
            8'h08: if (a != b) npc = npc + off * 4;
            8'h09: begin w = 1'b1; r = (amt >= dw) ? 0 : (a << amt); end
            8'h0A: begin w = 1'b1; r = (amt >= dw) ? 0 : (a >> amt); end
            8'h0B: begin
                w  = 1'b1;
                sv = (a >= (longint'(1) << (dw - 1))) ? a - (m + 1) : a;
                sh = (amt >= dw) ? dw - 1 : amt;
                r  = sv >>> sh;
            end
            8'h0C: begin
                w  = 1'b1;
                sh = amt % dw;
                r  = (a >> sh) | (a << (dw - sh));
            end
            8'h0D, 8'h0E: begin w = 1'b1; r = longint'(rdv); end
            8'hFF: begin mhalt[k] = 1'b1; npc = longint'(mpc[k]); end
            default: ;
        endcase
        if (w) mregs[k][rd] = 16'(r & m);
        mpc[k] = 32'(npc);
    endtask

    // Issue one instruction: ib fetch-stall cycles, mb data-stall cycles.
    task automatic step(input logic [31:0] ins, input int ib, input int mb);
        logic [7:0]  op;
        bit          is_mem, is_rd;
        logic [15:0] ea [2];
        logic [15:0] rdv [2];
        op     = ins[31:24];
        is_mem = (op >= 8'h0D && op <= 8'h10);
        is_rd  = (op == 8'h0D || op == 8'h0E);
        rdv[0] = '0;
        rdv[1] = '0;
        for (int c = 0; c < ib; c++) begin
            instr = $urandom();
            ibusy = 1'b1;
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) check("pc_fetch_stall", k, o_pc(k), mpc[k]);
        end
        instr = ins;
        ibusy = 1'b0;
        @(posedge clk); #1;
        instr = $urandom();
        for (int k = 0; k < 2; k++) check("pc_in_exec", k, o_pc(k), mpc[k]);
        @(posedge clk); #1;
        if (is_mem) begin
            for (int k = 0; k < 2; k++) begin
                ea[k] = model_addr(k, ins);
                check("mem_req", k, o_req(k), is_rd ? 2'b10 : 2'b01);
                check("mem_addr", k, o_addr(k), ea[k]);
                if (!is_rd) check("mem_wdata", k, o_wd(k), model_wdata(k, ins));
                check("pc_in_mem", k, o_pc(k), mpc[k]);
                rdv[k] = dm_has(k, ea[k]) ? dm_get(k, ea[k]) : 16'($urandom());
                if (k == 0) rdv[k] = rdv[k] & 16'h00FF;
            end
            rdata8  = rdv[0][7:0];
            rdata16 = rdv[1];
            for (int c = 0; c < mb; c++) begin
                mbusy = 1'b1;
                @(posedge clk); #1;
                for (int k = 0; k < 2; k++) begin
                    check("mem_req_held", k, o_req(k), is_rd ? 2'b10 : 2'b01);
                    check("mem_addr_held", k, o_addr(k), ea[k]);
                    check("pc_mem_stall", k, o_pc(k), mpc[k]);
                end
            end
            mbusy = 1'b0;
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                if (!is_rd) begin
                    if (k == 0) dm0[int'(ea[0])] = model_wdata(0, ins);
                    else        dm1[int'(ea[1])] = model_wdata(1, ins);
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            model_exec(k, ins, rdv[k]);
            check("mem_req_idle", k, o_req(k), 2'b00);
            check("pc", k, o_pc(k), mpc[k]);
            check("halted", k, o_halt(k), mhalt[k]);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 2; k++) check("pc_after_reset", k, o_pc(k), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ins;
        int          sel;
        rst = 1'b1; ibusy = 1'b0; mbusy = 1'b0; instr = '0; rdata8 = '0; rdata16 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_pc", k, o_pc(k), 32'h0);
            check("rst_req", k, o_req(k), 2'b00);
            check("rst_addr", k, o_addr(k), 16'h0);
            check("rst_wdata", k, o_wd(k), 16'h0);
            check("rst_halted", k, o_halt(k), 1'b0);
        end
        rst = 1'b0;

        // loadi r1,5; loadi r2,3; sub r3,r1,r2; store r3
        step(32'h00010005, 0, 0);
        step(32'h00020003, 0, 0);
        step(32'h03030102, 0, 0);
        for (int k = 0; k < 2; k++) check("pc_after_3", k, o_pc(k), 32'd12);
        step(32'h10000320, 0, 0);

        // Reset in the middle of a stalled store.
        instr = 32'h10000330;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mbusy = 1'b1;
        for (int k = 0; k < 2; k++) check("midrst_req_before", k, o_req(k), 2'b01);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("midrst_pc", k, o_pc(k), 32'h0);
            check("midrst_req", k, o_req(k), 2'b00);
            check("midrst_addr", k, o_addr(k), 16'h0);
        end
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        mbusy = 1'b0;
        step(32'h10000331, 0, 0);

        // Shifts on 0x81
        step(32'h00010081, 0, 0);
        step(32'h09050101, 0, 0);
        step(32'h0A060109, 0, 0);
        step(32'h0B070109, 0, 0);
        step(32'h0C040101, 0, 0);
        step(32'h10000540, 0, 0);
        step(32'h10000641, 0, 0);
        step(32'h10000742, 0, 1);
        step(32'h10000443, 0, 2);

        // Branches and jump from known PCs.
        do_reset();
        step(32'h42000000, 0, 0);
        step(32'h42000000, 0, 0);
        step(32'h07FD0102, 0, 0);
        step(32'h42000000, 0, 0);
        step(32'h42000000, 0, 0);
        step(32'h08FD0102, 0, 0);
        step(32'h07FC0102, 0, 0);
        step(32'h06020000, 0, 0);

        // Store/load through a slow data memory.
        step(32'h000600AA, 0, 0);
        step(32'h10000610, 0, 3);
        step(32'h0E040010, 0, 3);
        step(32'h10000411, 0, 0);

        // 0xFFFF + 2 (wraps differently per width), unknown opcode
        step(32'h00010000, 0, 0);
        step(32'h00020001, 0, 0);
        step(32'h030E0102, 0, 0);
        step(32'h000D0002, 0, 0);
        step(32'h020F0E0D, 0, 0);
        step(32'h10000F50, 0, 0);
        step(32'h42123456, 0, 0);

        // Randomized instruction stream
        for (int n = 0; n < 160; n++) begin
            ins = $urandom();
            sel = $urandom_range(0, 9);
            if (sel <= 1)      ins[31:24] = ($urandom_range(0, 1) == 0) ? 8'h0F : 8'h10;
            else if (sel == 2) ins[31:24] = ($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0E;
            else if (sel == 3) ins[31:24] = 8'(6 + $urandom_range(0, 2));
            else if (sel == 4) ins[31:24] = 8'(8'h11 + $urandom_range(0, 8'hED));
            else               ins[31:24] = alu_ops[$urandom_range(0, 9)];
            step(ins, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // Fetch stall, then halt and stay frozen.
        step(32'h00050077, 2, 0);
        step(32'h10000560, 0, 0);
        step(32'hFF000000, 1, 0);
        for (int c = 0; c < 20; c++) begin
            instr = $urandom();
            ibusy = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                check("halt_pc_frozen", k, o_pc(k), mpc[k]);
                check("halt_req", k, o_req(k), 2'b00);
                check("halt_flag", k, o_halt(k), 1'b1);
            end
        end
        ibusy = 1'b0;
        do_reset();
        for (int k = 0; k < 2; k++) check("halt_cleared", k, o_halt(k), 1'b0);
        step(32'h00010009, 0, 0);
        step(32'h10000170, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
